// File: rtl/regfile_port_ctrl.sv
// Processor-side access controller for a 32x32 register file: two-operand fetch
// with bypass of the draining writeback, register-0 semantics and a 2-entry write queue.
module regfile_port_ctrl #(
  parameter int N     = 32,
  parameter int R     = 32,
  parameter int ASIZE = $clog2(R)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ASIZE-1:0] req_rs1,
  input  logic [ASIZE-1:0] req_rs2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_data1,
  output logic [N-1:0]     rsp_data2,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [ASIZE-1:0] wb_id,
  input  logic [N-1:0]     wb_data,
  output logic [ASIZE-1:0] rf_reg_id_r1,
  output logic [ASIZE-1:0] rf_reg_id_r2,
  input  logic [N-1:0]     rf_data_out1,
  input  logic [N-1:0]     rf_data_out2,
  output logic [ASIZE-1:0] rf_reg_id_w,
  output logic [N-1:0]     rf_data_in,
  output logic             rf_wr
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t           state_q, state_d;
  logic [ASIZE-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [ASIZE-1:0] rd_id1_q, rd_id1_d, rd_id2_q, rd_id2_d;
  logic [N-1:0]     rsp_data1_q, rsp_data1_d, rsp_data2_q, rsp_data2_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ASIZE-1:0] q_id_q   [2];
  logic [ASIZE-1:0] q_id_d   [2];
  logic [N-1:0]     q_data_q [2];
  logic [N-1:0]     q_data_d [2];
  logic             head_q, head_d;
  logic [1:0]       count_q, count_d;

  logic             pop, push, tail, accept;
  logic [ASIZE-1:0] head_id;
  logic [N-1:0]     head_data;

  always_comb begin
    head_id   = q_id_q[head_q];
    head_data = q_data_q[head_q];
    // Draining is held off in ISSUE so the file is stable while it samples the read ids
    pop       = (count_q != 2'd0) && (state_q != ISSUE);
    wb_ready  = rst && (count_q != 2'd2);
    push      = wb_valid && wb_ready;
    tail      = head_q ^ count_q[0];
    req_ready = rst && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    accept    = req_valid && req_ready;

    rf_wr        = pop && (head_id != '0);
    rf_reg_id_w  = head_id;
    rf_data_in   = head_data;
    rf_reg_id_r1 = rd_id1_q;
    rf_reg_id_r2 = rd_id2_q;
    rsp_valid    = rsp_valid_q;
    rsp_data1    = rsp_data1_q;
    rsp_data2    = rsp_data2_q;

    q_id_d   = q_id_q;
    q_data_d = q_data_q;
    if (push) begin
      q_id_d[tail]   = wb_id;
      q_data_d[tail] = wb_data;
    end
    head_d  = pop ? ~head_q : head_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rsp_data1_d = rsp_data1_q;
    rsp_data2_d = rsp_data2_q;
    case (state_q)
      IDLE: if (accept) state_d = ISSUE;
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        // The write committing at this edge is invisible to the file read, so forward it
        if (rs1_q == '0)                      rsp_data1_d = '0;
        else if (rf_wr && (head_id == rs1_q)) rsp_data1_d = head_data;
        else                                  rsp_data1_d = rf_data_out1;
        if (rs2_q == '0)                      rsp_data2_d = '0;
        else if (rf_wr && (head_id == rs2_q)) rsp_data2_d = head_data;
        else                                  rsp_data2_d = rf_data_out2;
        state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = req_valid ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      rs1_d = req_rs1;
      rs2_d = req_rs2;
    end

    rsp_valid_d = (state_d == RESP);
    rd_id1_d    = (state_d == ISSUE) ? rs1_d : '0;
    rd_id2_d    = (state_d == ISSUE) ? rs2_d : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_id1_q    <= '0;
      rd_id2_q    <= '0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
      rsp_valid_q <= 1'b0;
      q_id_q[0]   <= '0;
      q_id_q[1]   <= '0;
      q_data_q[0] <= '0;
      q_data_q[1] <= '0;
      head_q      <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_id1_q    <= rd_id1_d;
      rd_id2_q    <= rd_id2_d;
      rsp_data1_q <= rsp_data1_d;
      rsp_data2_q <= rsp_data2_d;
      rsp_valid_q <= rsp_valid_d;
      q_id_q      <= q_id_d;
      q_data_q    <= q_data_d;
      head_q      <= head_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a behavioural one-cycle-latency register file.
module tb_regfile_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4:0]  req_rs1, req_rs2;
  logic [31:0] rsp_data1, rsp_data2;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_id;
  logic [31:0] wb_data;
  logic [4:0]  rf_reg_id_r1, rf_reg_id_r2, rf_reg_id_w;
  logic [31:0] rf_data_out1, rf_data_out2, rf_data_in;
  logic        rf_wr;

  logic        pl_en;
  logic [4:0]  pl_id;
  logic [31:0] pl_d;
  logic [31:0] rf_mem [32];
  int          wr_count = 0;
  int          passed = 0;
  int          total = 0;
  int          wr_before;

  always #5 clk = ~clk;

  regfile_port_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_id(wb_id), .wb_data(wb_data),
    .rf_reg_id_r1(rf_reg_id_r1), .rf_reg_id_r2(rf_reg_id_r2),
    .rf_data_out1(rf_data_out1), .rf_data_out2(rf_data_out2),
    .rf_reg_id_w(rf_reg_id_w), .rf_data_in(rf_data_in), .rf_wr(rf_wr)
  );

  // Register-file model: reads registered, same-edge read returns old value
  always @(posedge clk) begin
    rf_data_out1 <= rf_mem[rf_reg_id_r1];
    rf_data_out2 <= rf_mem[rf_reg_id_r2];
    if (pl_en)      rf_mem[pl_id] <= pl_d;
    else if (rf_wr) rf_mem[rf_reg_id_w] <= rf_data_in;
    if (rf_wr) wr_count <= wr_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input logic [4:0] id, input logic [31:0] d);
    pl_en = 1'b1; pl_id = id; pl_d = d;
    tick();
    pl_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_rs1 = '0; req_rs2 = '0;
    wb_valid = 1'b0; wb_id = '0; wb_data = '0; pl_en = 1'b0; pl_id = '0; pl_d = '0;
    tick(); tick();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_wb_ready", {31'b0, wb_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rf_wr", {31'b0, rf_wr}, 32'd0);
    chk("rst_rsp_data1", rsp_data1, 32'd0);
    chk("rst_rf_id_r1", {27'b0, rf_reg_id_r1}, 32'd0);
    chk("rst_rf_data_in", rf_data_in, 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rel_wb_ready", {31'b0, wb_ready}, 32'd1);
    tick();
    preload(5'd5, 32'h55); preload(5'd6, 32'h66);
    preload(5'd7, 32'h11); preload(5'd0, 32'hDEAD);

    // Plain read rs1=5, rs2=6
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6;
    tick();
    req_valid = 1'b0;
    chk("t1_issue_id1", {27'b0, rf_reg_id_r1}, 32'd5);
    chk("t1_issue_id2", {27'b0, rf_reg_id_r2}, 32'd6);
    chk("t1_issue_req_ready", {31'b0, req_ready}, 32'd0);
    tick();
    chk("t1_capture_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("t1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t1_rsp_data1", rsp_data1, 32'h55);
    chk("t1_rsp_data2", rsp_data2, 32'h66);
    chk("t1_resp_id1", {27'b0, rf_reg_id_r1}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t1_idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("t1_idle_req_ready", {31'b0, req_ready}, 32'd1);

    // Register 0 reads and writes
    req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd0;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    chk("t2_r0_data1", rsp_data1, 32'd0);
    chk("t2_r0_data2", rsp_data2, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    wb_valid = 1'b1; wb_id = 5'd0; wb_data = 32'h1;
    tick();
    wb_valid = 1'b0;
    chk("t2_w0_head_data", rf_data_in, 32'h1);
    chk("t2_w0_rf_wr", {31'b0, rf_wr}, 32'd0);
    tick();
    chk("t2_w0_rf_wr_after", {31'b0, rf_wr}, 32'd0);
    chk("t2_rf0_kept", rf_mem[0], 32'hDEAD);

    // Writeback pushed during ISSUE bypasses into CAPTURE (duplicate ids)
    req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd7;
    tick();
    req_valid = 1'b0;
    wb_valid = 1'b1; wb_id = 5'd7; wb_data = 32'hA1;
    chk("t3_issue_wb_ready", {31'b0, wb_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
    chk("t3_capture_rf_wr", {31'b0, rf_wr}, 32'd1);
    chk("t3_capture_wid", {27'b0, rf_reg_id_w}, 32'd7);
    tick();
    chk("t3_rsp_data1", rsp_data1, 32'hA1);
    chk("t3_rsp_data2", rsp_data2, 32'hA1);
    chk("t3_rf7", rf_mem[7], 32'hA1);
    chk("t3_resp_rf_wr", {31'b0, rf_wr}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Queue fills to 2 during ISSUE, then drains in order
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6;
    wb_valid = 1'b1; wb_id = 5'd8; wb_data = 32'h88;
    tick();
    req_valid = 1'b0;
    wb_id = 5'd9; wb_data = 32'h99;
    chk("t4_issue_wb_ready", {31'b0, wb_ready}, 32'd1);
    chk("t4_issue_stall", {31'b0, rf_wr}, 32'd0);
    tick();
    wb_valid = 1'b0;
    chk("t4_full_wb_ready", {31'b0, wb_ready}, 32'd0);
    chk("t4_pop1_wr", {31'b0, rf_wr}, 32'd1);
    chk("t4_pop1_id", {27'b0, rf_reg_id_w}, 32'd8);
    chk("t4_pop1_data", rf_data_in, 32'h88);
    tick();
    chk("t4_resp_wb_ready", {31'b0, wb_ready}, 32'd1);
    chk("t4_pop2_wr", {31'b0, rf_wr}, 32'd1);
    chk("t4_pop2_id", {27'b0, rf_reg_id_w}, 32'd9);
    chk("t4_pop2_data", rf_data_in, 32'h99);
    chk("t4_rsp_data1", rsp_data1, 32'h55);
    chk("t4_rsp_data2", rsp_data2, 32'h66);
    tick();
    chk("t4_empty_rf_wr", {31'b0, rf_wr}, 32'd0);
    chk("t4_rf8", rf_mem[8], 32'h88);
    chk("t4_rf9", rf_mem[9], 32'h99);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Held response is a snapshot; RESP -> ISSUE on back-to-back request
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    wb_valid = 1'b1; wb_id = 5'd5; wb_data = 32'h5A;
    tick();
    wb_valid = 1'b0;
    chk("t5_resp_drain_wr", {31'b0, rf_wr}, 32'd1);
    chk("t5_hold_data1_a", rsp_data1, 32'h55);
    chk("t5_hold_req_ready", {31'b0, req_ready}, 32'd0);
    tick();
    chk("t5_hold_data1_b", rsp_data1, 32'h55);
    chk("t5_hold_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t5_rf5", rf_mem[5], 32'h5A);
    tick(); tick();
    chk("t5_hold_data1_c", rsp_data1, 32'h55);
    rsp_ready = 1'b1; req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd5;
    #1;
    chk("t5_release_req_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("t5_direct_issue_id", {27'b0, rf_reg_id_r1}, 32'd5);
    chk("t5_direct_issue_valid", {31'b0, rsp_valid}, 32'd0);
    tick(); tick();
    chk("t5_new_data1", rsp_data1, 32'h5A);
    chk("t5_new_data2", rsp_data2, 32'h5A);
    tick();
    rsp_ready = 1'b0;

    // Reset during CAPTURE with two queued writes
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6;
    wb_valid = 1'b1; wb_id = 5'd10; wb_data = 32'hA0;
    tick();
    req_valid = 1'b0;
    wb_id = 5'd11; wb_data = 32'hB0;
    tick();
    wb_valid = 1'b0;
    wr_before = wr_count;
    rst = 1'b0;
    #1;
    chk("t6_rst_rf_wr", {31'b0, rf_wr}, 32'd0);
    chk("t6_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("t6_rst_wb_ready", {31'b0, wb_ready}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_rel_req_ready", {31'b0, req_ready}, 32'd1);
    chk("t6_rel_rf_wr", {31'b0, rf_wr}, 32'd0);
    chk("t6_rel_rsp_data1", rsp_data1, 32'd0);
    tick(); tick(); tick();
    chk("t6_no_writes", wr_count, wr_before);
    chk("t6_idle_rf_wr", {31'b0, rf_wr}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
